pixel_write_sink: RTL and testbench
===================================

# pixel_write_sink

Pixel sink at the far end of the drawer pixel-write interface (`drawOnVGA`/`X`/`Y`/`color`). Accepts single-cycle pixel strobes from the map/sprite drawers, range-checks them, buffers them in a small FIFO, converts `(X,Y)` to a linear frame-buffer address, and issues writes to the frame-buffer port whenever memory grants a slot. A level `commit` handshake tells the game-state logic when every accepted pixel of a redraw has actually reached memory.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `WIDTH`, 320: screen width in pixels; also the address row stride.
- `HEIGHT`, 240: screen height in pixels.

Ports:
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `drawOnVGA`  in  1  pixel strobe; sampled every edge, one pixel per high cycle.
- `X`  in  9  pixel column.
- `Y`  in  8  pixel row.
- `color`  in  3  pixel color.
- `commit`  in  1  level request: "redraw finished, report when drained".
- `mem_grant`  in  1  frame-buffer port free this cycle.
- `mem_we`  out  1  frame-buffer write enable (registered).
- `mem_addr`  out  17  linear address `Y*WIDTH + X` (registered).
- `mem_data`  out  3  color to write (registered).
- `full`  out  1  FIFO holds DEPTH entries.
- `committed`  out  1  drain complete; level.
- `overflow`  out  1  sticky: a strobe arrived while full and was lost.
- `dropCount`  out  8  saturating count of out-of-range strobes.

## Operation
- **Range check.** A strobe is accepted only if `X < WIDTH` and `Y < HEIGHT`.
  - Out-of-range strobe: not pushed; `dropCount` increments and saturates at 255.
  - Strobe while `full` with no pop on the same edge: not pushed; `overflow` sets. It clears only on `reset`.
- **Address.** `mem_addr = Y*WIDTH + X`, computed at 17 bits with no truncation; the maximum is 76799 for the defaults. For `WIDTH=320` the computation is `(Y<<8) + (Y<<6) + X`.
- **FIFO.** Each entry holds {addr, color}. Circular read and write pointers with a separate occupancy count; the pointers wrap modulo DEPTH.
  - Push and pop on the same edge: both happen and occupancy is unchanged. This applies when full, so a strobe is accepted while full if a pop occurs on that edge.
  - Push on an empty FIFO is not bypassed. The pop of that entry can happen on the following edge at the earliest.
- **Write issue.** On an edge where the FIFO is non-empty and `mem_grant=1`, pop the head and register `mem_we=1`, `mem_addr`, `mem_data`. Otherwise `mem_we=0` and `mem_addr`/`mem_data` hold their values.
- **Commit FSM**, states RUN, DRAIN, DONE:
  - RUN: move to DRAIN when `commit=1`.
  - DRAIN: move to DONE on the first edge where the FIFO is empty and no pop occurs on that edge. Strobes keep being accepted during DRAIN and extend it.
  - DONE: `committed=1`. Return to RUN when `commit=0`. Strobes are still accepted; `committed` stays high until `commit` drops.
  - `commit` dropping during DRAIN: return to RUN, `committed` stays 0.
- **Reset.** Pointers and occupancy 0, FSM to RUN, `mem_we=0`, `mem_addr=0`, `mem_data=0`, `committed=0`, `overflow=0`, `dropCount=0`.
  - Reset has priority over every event on the same edge.
  - Reset mid-drain discards buffered pixels; no write is issued for them.

## Timing
- Strobe sampled at edge k, FIFO empty before it, `mem_grant` high → entry pushed at k, popped at k+1, so `mem_we` is high during the cycle after edge k+1.
- Throughput: one write per granted cycle.
- `full` and `committed` are derived from registered state and are valid in the cycle after the causing edge.
- DONE is entered no earlier than the edge after the last pop. `committed` therefore rises at the same edge that ends the last `mem_we` cycle or later.

## Test plan
- **Single pixel.** Reset, `mem_grant=1`, strobe X=5, Y=2, color=3 → exactly one `mem_we` pulse with addr 645, data 3, in the cycle after the next edge.
- **Bounds.** Strobes (319,239), (320,0), (0,240) → one write at addr 76799. `dropCount=2`. `overflow=0`.
- **Backpressure.** `mem_grant=0`, DEPTH+1 consecutive valid strobes → `full=1` after DEPTH, `overflow=1`. Then `mem_grant=1` → exactly DEPTH writes, in order, with no duplicates.
- **Full with simultaneous push/pop.** FIFO full, `mem_grant=1`, strobe on the same edge → strobe accepted, `overflow` stays 0, occupancy stays DEPTH.
- **Commit.** 3 pixels buffered, `mem_grant` toggling, `commit=1` → `committed` rises only after the third `mem_we`. Dropping `commit` → `committed=0` on the next cycle.
- **Reset mid-drain.** 4 pixels buffered, DRAIN active, `reset` pulsed → no further `mem_we`, all outputs at their reset values, `committed=0`.

Source files
------------

// File: rtl/pixel_write_sink.sv
// Frame-buffer pixel sink: range-checks drawer strobes, queues {addr,color} in a
// small FIFO, writes to memory on grant, and reports drain completion via commit.
module pixel_write_sink #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        drawOnVGA,
  input  logic [8:0]  X,
  input  logic [7:0]  Y,
  input  logic [2:0]  color,
  input  logic        commit,
  input  logic        mem_grant,
  output logic        mem_we,
  output logic [16:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        full,
  output logic        committed,
  output logic        overflow,
  output logic [7:0]  dropCount
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [19:0]     fifo_mem [DEPTH];
  logic [16:0]     lin_addr;
  logic            in_range, empty, pop, push;

  assign in_range = (int'(X) < WIDTH) && (int'(Y) < HEIGHT);
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop      = !empty && mem_grant;
  // A strobe may enter a full FIFO when the head leaves on the same edge.
  assign push     = drawOnVGA && in_range && (!full || pop);

  always_comb begin
    lin_addr = '0;
    if (WIDTH == 320)
      lin_addr = ({9'b0, Y} << 8) + ({9'b0, Y} << 6) + {8'b0, X};
    else
      lin_addr = ({9'b0, Y} * 17'(WIDTH)) + {8'b0, X};
  end

  always_ff @(posedge clock) begin
    if (push)
      fifo_mem[wr_ptr] <= {lin_addr, color};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      overflow  <= 1'b0;
      dropCount <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      mem_we <= pop;
      if (pop)
        {mem_addr, mem_data} <= fifo_mem[rd_ptr];
      if (drawOnVGA && in_range && full && !pop)
        overflow <= 1'b1;
      if (drawOnVGA && !in_range && dropCount != 8'hFF)
        dropCount <= dropCount + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  // An empty FIFO cannot pop, so emptiness alone marks the end of the drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (commit) state_d = DRAIN;
      DRAIN: begin
        if (!commit)
          state_d = RUN;
        else if (empty)
          state_d = DONE;
      end
      DONE:    if (!commit) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign committed = (state_q == DONE);

endmodule

// File: tb/tb_pixel_write_sink.sv
// Self-checking bench for pixel_write_sink: a queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_pixel_write_sink;

  localparam int DEPTH  = 8;
  localparam int WIDTH  = 320;
  localparam int HEIGHT = 240;

  logic        clock, reset, drawOnVGA, commit, mem_grant;
  logic [8:0]  X;
  logic [7:0]  Y;
  logic [2:0]  color;
  logic        mem_we, full, committed, overflow;
  logic [16:0] mem_addr;
  logic [2:0]  mem_data;
  logic [7:0]  dropCount;

  int checks = 0;
  int failures = 0;

  pixel_write_sink #(.DEPTH(DEPTH), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clock(clock), .reset(reset), .drawOnVGA(drawOnVGA), .X(X), .Y(Y),
    .color(color), .commit(commit), .mem_grant(mem_grant), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .full(full),
    .committed(committed), .overflow(overflow), .dropCount(dropCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit s, input int x, input int y, input int c,
                               input bit g, input bit cm);
    drawOnVGA = s;
    X         = 9'(x);
    Y         = 8'(y);
    color     = 3'(c);
    mem_grant = g;
    commit    = cm;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference model: pending pixels as a queue of addr*8+color, plus commit phase
  // (0 idle, 1 waiting for drain, 2 reported).
  int  modelQ[$];
  int  mWe, mAddr, mData, mOvf, mDrop, mPhase;
  bit  modelValid = 0;

  always @(posedge clock) begin
    int sz;
    bit popNow;
    bit inR;
    int e;
    if (reset) begin
      modelQ.delete();
      mWe = 0; mAddr = 0; mData = 0; mOvf = 0; mDrop = 0; mPhase = 0;
      modelValid = 1;
    end else begin
      sz     = modelQ.size();
      popNow = (sz > 0) && mem_grant;
      inR    = (X < WIDTH) && (Y < HEIGHT);
      if (popNow) begin
        e = modelQ.pop_front();
        mWe = 1; mAddr = e / 8; mData = e % 8;
      end else begin
        mWe = 0;
      end
      if (drawOnVGA) begin
        if (!inR) begin
          if (mDrop < 255) mDrop++;
        end else if (sz < DEPTH || popNow) begin
          modelQ.push_back((int'(Y) * WIDTH + int'(X)) * 8 + int'(color));
        end else begin
          mOvf = 1;
        end
      end
      case (mPhase)
        0: if (commit) mPhase = 1;
        1: if (!commit) mPhase = 0; else if (sz == 0) mPhase = 2;
        default: if (!commit) mPhase = 0;
      endcase
    end
  end

  always @(negedge clock) begin
    if (modelValid) begin
      checkOutput("mem_we", mem_we, mWe);
      checkOutput("mem_addr", mem_addr, mAddr);
      checkOutput("mem_data", mem_data, mData);
      checkOutput("full", full, modelQ.size() == DEPTH);
      checkOutput("committed", committed, mPhase == 2);
      checkOutput("overflow", overflow, mOvf);
      checkOutput("dropCount", dropCount, mDrop);
    end
  end

  int weCount = 0;
  int wrLog[$];
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      weCount++;
      wrLog.push_back(int'(mem_addr));
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_we"}, mem_we, 0);
    checkOutput({tag, "_addr"}, mem_addr, 0);
    checkOutput({tag, "_data"}, mem_data, 0);
    checkOutput({tag, "_full"}, full, 0);
    checkOutput({tag, "_committed"}, committed, 0);
    checkOutput({tag, "_overflow"}, overflow, 0);
    checkOutput({tag, "_dropCount"}, dropCount, 0);
  endtask

  task automatic resetDut();
    applyStimulus(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step(2);
    checkResetValues("reset");
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base, logBase, guard;
    reset = 1'b1;
    resetDut();

    // Single pixel: (5,2) -> 2*320+5 = 645
    base = weCount;
    applyStimulus(1, 5, 2, 3, 1, 0);
    step(1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("single_we_early", mem_we, 0);
    step(1);
    checkOutput("single_we", mem_we, 1);
    checkOutput("single_addr", mem_addr, 645);
    checkOutput("single_data", mem_data, 3);
    step(3);
    checkOutput("single_count", weCount - base, 1);

    // Bounds: only (319,239) is in range -> 239*320+319 = 76799
    resetDut();
    base = weCount;
    applyStimulus(1, 319, 239, 5, 1, 0); step(1);
    applyStimulus(1, 320, 0, 1, 1, 0);   step(1);
    applyStimulus(1, 0, 240, 2, 1, 0);   step(1);
    applyStimulus(0, 0, 0, 0, 1, 0);     step(3);
    checkOutput("bounds_count", weCount - base, 1);
    checkOutput("bounds_addr", wrLog[wrLog.size()-1], 76799);
    checkOutput("bounds_drop", dropCount, 2);
    checkOutput("bounds_overflow", overflow, 0);

    // Backpressure: DEPTH+1 strobes without grant, then drain in order
    resetDut();
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(1, i, 10, i % 8, 0, 0);
      step(1);
      if (i == DEPTH - 1) begin
        checkOutput("bp_full", full, 1);
        checkOutput("bp_no_overflow_yet", overflow, 0);
      end
    end
    checkOutput("bp_overflow", overflow, 1);
    base = weCount;
    logBase = wrLog.size();
    applyStimulus(0, 0, 0, 0, 1, 0);
    step(DEPTH + 3);
    checkOutput("bp_count", weCount - base, DEPTH);
    for (int i = 0; i < DEPTH; i++)
      if (logBase + i < wrLog.size())
        checkOutput("bp_order", wrLog[logBase + i], 10 * 320 + i);
    checkOutput("bp_drained", full, 0);

    // Full FIFO with simultaneous push and pop
    resetDut();
    base = weCount;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 20 + i, 1, 1, 0, 0);
      step(1);
    end
    checkOutput("pp_full_before", full, 1);
    applyStimulus(1, 100, 100, 6, 1, 0);
    step(1);
    checkOutput("pp_full_after", full, 1);
    checkOutput("pp_overflow", overflow, 0);
    checkOutput("pp_we", mem_we, 1);
    checkOutput("pp_first_addr", mem_addr, 320 + 20);
    applyStimulus(0, 0, 0, 0, 1, 0);
    step(DEPTH + 2);
    checkOutput("pp_count", weCount - base, DEPTH + 1);
    checkOutput("pp_last_addr", wrLog[wrLog.size()-1], 100 * 320 + 100);

    // Commit with toggling grant
    resetDut();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1, i, 3, i, 0, 0);
      step(1);
    end
    base = weCount;
    guard = 0;
    while (committed !== 1'b1 && guard < 40) begin
      applyStimulus(0, 0, 0, 0, guard % 2 == 0, 1);
      step(1);
      guard++;
    end
    checkOutput("commit_reached", committed, 1);
    checkOutput("commit_writes_before", weCount - base, 3);
    checkOutput("commit_we_done", mem_we, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    step(1);
    checkOutput("commit_drop", committed, 0);

    // Reset mid-drain discards buffered pixels
    resetDut();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 50 + i, 7, 2, 0, 0);
      step(1);
    end
    applyStimulus(0, 0, 0, 0, 0, 1);
    step(2);
    checkOutput("rd_draining", committed, 0);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 1);
    step(1);
    checkResetValues("rd_reset");
    reset = 1'b0;
    base = weCount;
    applyStimulus(0, 0, 0, 0, 1, 0);
    step(5);
    checkOutput("rd_no_writes", weCount - base, 0);
    checkOutput("rd_committed", committed, 0);

    // dropCount saturation
    resetDut();
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1, 400, 0, 0, 1, 0);
      step(1);
    end
    checkOutput("drop_saturate", dropCount, 255);

    // Randomized traffic, grant pressure varies per block of cycles
    resetDut();
    begin
      bit cm;
      int grantPct;
      cm = 0;
      grantPct = 60;
      for (int i = 0; i < 3000; i++) begin
        if (i % 100 == 0) grantPct = $urandom_range(10, 90);
        if ($urandom_range(0, 19) == 0) cm = ~cm;
        reset = ($urandom_range(0, 299) == 0);
        applyStimulus($urandom_range(0, 1), $urandom_range(0, 335),
                      $urandom_range(0, 250), $urandom_range(0, 7),
                      $urandom_range(0, 99) < grantPct, cm);
        step(1);
      end
      reset = 1'b0;
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    step(DEPTH + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
